// File: rtl/sobol_stream_gen.sv
// sobol_stream_gen -- Sobol-based unary stream generator.
// On an accepted start the input value is latched and compared against
// N = 2^RWID consecutive words of an upstream 1-D Sobol sequence. Each
// comparison yields one stream bit, so the stream carries exactly inVal ones.
// Optional feature: define SOBOL_STREAM_ONES_CNT_EN to add the onesCnt port
// and its counter.
module sobol_stream_gen #(
  parameter int RWID = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [RWID-1:0] inVal,
  input  logic [RWID-1:0] rngSeq,
  output logic            rngEn,
  output logic            bitOut,
  output logic            bitVld,
  output logic            busy,
  output logic            done
`ifdef SOBOL_STREAM_ONES_CNT_EN
  ,
  output logic [RWID-1:0] onesCnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Value of the length counter during the final (N-th) RUN cycle.
  localparam logic [RWID:0] LEN_LAST = {1'b0, {RWID{1'b1}}};

  state_t          state_q, state_d;
  logic [RWID:0]   len_q, len_d;
  logic [RWID-1:0] inval_q, inval_d;
  logic            bit_out_q, bit_out_d;
  logic            bit_vld_q, bit_vld_d;

  // A RUN cycle whose comparison actually reaches the output; an abort
  // in the same cycle suppresses the bit.
  logic run_go;
  logic cmp_one;
  logic accept;

  assign run_go  = (state_q == S_RUN) && !abort;
  assign cmp_one = inval_q > rngSeq;
  // Abort has priority over start, so a coincident abort blocks acceptance.
  assign accept  = (state_q == S_IDLE) && start && !abort;

  // Next-state and datapath decode for the stream FSM.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    len_d     = len_q;
    inval_d   = inval_q;
    bit_out_d = run_go && cmp_one;
    bit_vld_d = run_go;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_RUN;
          inval_d = inVal;
          len_d   = '0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          len_d = len_q + (RWID+1)'(1);
          if (len_q == LEN_LAST) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered stream outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      inval_q   <= '0;
      bit_out_q <= 1'b0;
      bit_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      inval_q   <= inval_d;
      bit_out_q <= bit_out_d;
      bit_vld_q <= bit_vld_d;
    end
  end

  // The RNG is stepped combinationally from the state so it advances in
  // lock-step with the RUN cycles: exactly N steps per stream.
  assign rngEn  = (state_q == S_RUN);
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign bitOut = bit_out_q;
  assign bitVld = bit_vld_q;

`ifdef SOBOL_STREAM_ONES_CNT_EN
  logic [RWID-1:0] ones_q, ones_d;

  // Ones counter: counts at comparison time rather than at the registered
  // output, so it already includes the final bit in the done cycle.
  always_comb begin
    ones_d = ones_q;
    if (accept) begin
      ones_d = '0;
    end else if (run_go && cmp_one) begin
      ones_d = ones_q + RWID'(1);
    end
  end

  // Ones counter register; holds after done until the next accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ones_q <= '0;
    end else begin
      ones_q <= ones_d;
    end
  end

  assign onesCnt = ones_q;
`else
  // Ones counter not built in this configuration.
`endif

endmodule

// File: tb/tb_sobol_stream_gen.sv
// tb_sobol_stream_gen -- directed bench for sobol_stream_gen (RWID = 8).
// The upstream RNG is modelled as a van der Corput (bit-reversed counter)
// sequence that steps only on rngEn and is never reset, so its phase drifts
// between streams.
module tb_sobol_stream_gen;

  localparam int RWID = 8;
  localparam int N    = 1 << RWID;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            abort;
  logic [RWID-1:0] inVal;
  logic [RWID-1:0] rngSeq;
  logic            rngEn;
  logic            bitOut;
  logic            bitVld;
  logic            busy;
  logic            done;
`ifdef SOBOL_STREAM_ONES_CNT_EN
  logic [RWID-1:0] onesCnt;
`endif

  sobol_stream_gen #(.RWID(RWID)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .inVal  (inVal),
    .rngSeq (rngSeq),
    .rngEn  (rngEn),
    .bitOut (bitOut),
    .bitVld (bitVld),
    .busy   (busy),
    .done   (done)
`ifdef SOBOL_STREAM_ONES_CNT_EN
    ,
    .onesCnt(onesCnt)
`endif
  );

  always #5 clk = ~clk;

  // Upstream RNG model: starts at an arbitrary phase.
  logic [RWID-1:0] rng_idx = 8'd37;

  always @(posedge clk) begin
    if (rngEn) rng_idx <= rng_idx + 8'd1;
  end

  function automatic logic [RWID-1:0] bitrev(input logic [RWID-1:0] x);
    logic [RWID-1:0] r;
    for (int i = 0; i < RWID; i++) r[i] = x[RWID-1-i];
    return r;
  endfunction

  assign rngSeq = bitrev(rng_idx);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Per-window observation counters.
  int vld_cnt, ones_cnt, rngen_cnt, done_cnt, done_with_vld;
  int first_vld_j, last_vld_j, done_j;
  int snap_j;
  int snap_vld, snap_out, snap_busy, snap_done, snap_rngen, snap_ones;

  task automatic clear_counters(input int snap_at);
    vld_cnt = 0; ones_cnt = 0; rngen_cnt = 0; done_cnt = 0; done_with_vld = 0;
    first_vld_j = -1; last_vld_j = -1; done_j = -1;
    snap_j = snap_at;
    snap_vld = -1; snap_out = -1; snap_busy = -1; snap_done = -1;
    snap_rngen = -1; snap_ones = -1;
  endtask

  // Advance one clock and sample outputs 1 ns after the edge as cycle j.
  task automatic tick_sample(input int j);
    @(posedge clk);
    #1;
    if (bitVld) begin
      vld_cnt++;
      if (first_vld_j < 0) first_vld_j = j;
      last_vld_j = j;
      if (bitOut) ones_cnt++;
    end
    if (rngEn) rngen_cnt++;
    if (done) begin
      done_cnt++;
      done_j = j;
      if (bitVld) done_with_vld++;
    end
    if (j == snap_j) begin
      snap_vld   = int'(bitVld);
      snap_out   = int'(bitOut);
      snap_busy  = int'(busy);
      snap_done  = int'(done);
      snap_rngen = int'(rngEn);
`ifdef SOBOL_STREAM_ONES_CNT_EN
      snap_ones  = int'(onesCnt);
`else
      snap_ones  = 0;
`endif
    end
  endtask

  localparam int EV_NONE    = 0;
  localparam int EV_RESTART = 1;
  localparam int EV_ABORT   = 2;
  localparam int EV_RESET   = 3;

  // Pulse (or hold) start with value v; the start cycle is cycle 0 and the
  // window samples cycles 1..ncyc. An optional event is applied in cycle ev_j
  // and outputs are snapshotted in cycle ev_j+1.
  task automatic run_window(input logic [RWID-1:0] v, input int ncyc,
                            input bit hold, input int ev_kind, input int ev_j,
                            input logic [RWID-1:0] ev_val);
    clear_counters(ev_j + 1);
    inVal = v;
    start = 1'b1;
    abort = 1'b0;
    rst_n = 1'b1;
    for (int j = 1; j <= ncyc; j++) begin
      tick_sample(j);
      start = hold && (j < ncyc);
      inVal = v;
      abort = 1'b0;
      rst_n = 1'b1;
      if (j == ev_j) begin
        case (ev_kind)
          EV_RESTART: begin start = 1'b1; inVal = ev_val; end
          EV_ABORT:   abort = 1'b1;
          EV_RESET:   rst_n = 1'b0;
          default:    ;
        endcase
      end
    end
    start = 1'b0;
  endtask

  // Full-stream expectations: bitVld in cycles 2..N+1, done only at N+1.
  task automatic check_stream(input string name, input int exp_ones);
    check({name, " vld_cnt"},   vld_cnt, N);
    check({name, " ones"},      ones_cnt, exp_ones);
    check({name, " rngen_cnt"}, rngen_cnt, N);
    check({name, " first_vld"}, first_vld_j, 2);
    check({name, " last_vld"},  last_vld_j, N + 1);
    check({name, " done_cnt"},  done_cnt, 1);
    check({name, " done_at"},   done_j, N + 1);
    check({name, " done_vld"},  done_with_vld, 1);
    check({name, " busy_end"},  int'(busy), 0);
`ifdef SOBOL_STREAM_ONES_CNT_EN
    check({name, " onesCnt"},   int'(onesCnt), exp_ones);
`endif
  endtask

  typedef struct {
    string           name;
    logic [RWID-1:0] inval;
    int              exp_ones;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{name: "v100", inval: 8'd100, exp_ones: 100};
    vecs[1] = '{name: "v0",   inval: 8'd0,   exp_ones: 0};
    vecs[2] = '{name: "v255", inval: 8'd255, exp_ones: 255};
    vecs[3] = '{name: "v1",   inval: 8'd1,   exp_ones: 1};
    vecs[4] = '{name: "v128", inval: 8'd128, exp_ones: 128};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    inVal = '0;
    clear_counters(-10);
    for (int j = 0; j < 3; j++) tick_sample(j);
    check("rst bitVld", int'(bitVld), 0);
    check("rst bitOut", int'(bitOut), 0);
    check("rst busy",   int'(busy),   0);
    check("rst done",   int'(done),   0);
    check("rst rngEn",  int'(rngEn),  0);
`ifdef SOBOL_STREAM_ONES_CNT_EN
    check("rst onesCnt", int'(onesCnt), 0);
`endif
    rst_n = 1'b1;
    tick_sample(0);

    // Abort while idle must leave the block idle.
    abort = 1'b1;
    tick_sample(0);
    abort = 1'b0;
    tick_sample(0);
    check("idle abort busy", int'(busy), 0);

    // Table-driven single streams.
    foreach (vecs[i]) begin
      run_window(vecs[i].inval, N + 3, 1'b0, EV_NONE, -10, '0);
      check_stream(vecs[i].name, vecs[i].exp_ones);
    end

    // Start re-pulsed mid-run with a different value: ignored.
    run_window(8'd200, N + 3, 1'b0, EV_RESTART, 20, 8'd7);
    check_stream("restart", 200);

    // Abort in RUN cycle 50: idle next cycle, no done.
    run_window(8'd77, N + 3, 1'b0, EV_ABORT, 50, '0);
    check("abort vld_next",  snap_vld, 0);
    check("abort busy_next", snap_busy, 0);
    check("abort done_next", snap_done, 0);
    check("abort vld_cnt",   vld_cnt, 49);
    check("abort done_cnt",  done_cnt, 0);
    run_window(8'd33, N + 3, 1'b0, EV_NONE, -10, '0);
    check_stream("post_abort", 33);

    // Reset in RUN cycle 10: all outputs zero next cycle, no done.
    run_window(8'd90, N + 3, 1'b0, EV_RESET, 10, '0);
    check("rstrun vld",      snap_vld, 0);
    check("rstrun out",      snap_out, 0);
    check("rstrun busy",     snap_busy, 0);
    check("rstrun done",     snap_done, 0);
    check("rstrun rngEn",    snap_rngen, 0);
    check("rstrun ones",     snap_ones, 0);
    check("rstrun done_cnt", done_cnt, 0);
    check("rstrun vld_cnt",  vld_cnt, 9);
    run_window(8'd64, N + 3, 1'b0, EV_NONE, -10, '0);
    check_stream("post_reset", 64);

    // Start held high: streams repeat with period N+2, three in the window.
    clear_counters(N + 2);
    inVal = 8'd1;
    start = 1'b1;
    for (int j = 1; j <= 3 * N + 5; j++) tick_sample(j);
    start = 1'b0;
    check("b2b idle_after_done", snap_busy, 0);
    check("b2b done_cnt",  done_cnt, 3);
    check("b2b ones",      ones_cnt, 3);
    check("b2b vld_cnt",   vld_cnt, 3 * N);
    check("b2b rngen_cnt", rngen_cnt, 3 * N);
    check("b2b done_vld",  done_with_vld, 3);
    check("b2b last_done", done_j, 3 * N + 5);
    tick_sample(0);
    tick_sample(0);
    check("b2b busy_end", int'(busy), 0);
`ifdef SOBOL_STREAM_ONES_CNT_EN
    check("b2b onesCnt", int'(onesCnt), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sobol_stream_gen.md
SOBOL_STREAM_GEN -- requirements
Module: sobol_stream_gen

Interface
REQ-001 Parameter RWID, default 8: width of the input value and of the RNG word; stream length N = 2^RWID.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 start  input  1  request to generate one stream; accepted only in IDLE.
REQ-005 abort  input  1  synchronous cancel of a running stream.
REQ-006 inVal  input  RWID  unsigned binary value to encode; sampled when start is accepted.
REQ-007 rngSeq  input  RWID  Sobol word from the upstream 1-D Sobol RNG sequence output.
REQ-008 rngEn  output  1  enable driven to the upstream RNG; advances it one step per cycle.
REQ-009 bitOut  output  1  unary stream bit.
REQ-010 bitVld  output  1  bitOut is valid this cycle.
REQ-011 busy  output  1  high in RUN and DONE.
REQ-012 done  output  1  one-cycle end-of-stream pulse.
REQ-013 onesCnt  output  RWID  count of ones emitted in the current or last stream (present only with the macro below).

Function
REQ-014 FSM states: IDLE, RUN, DONE. Transitions: IDLE->RUN on start; RUN->DONE after exactly N RUN cycles; DONE->IDLE unconditionally after one cycle.
REQ-015 Start acceptance at cycle t (IDLE && start): inValReg <= inVal; length counter (RWID+1 bits) <= 0; RUN occupies cycles t+1 .. t+N.
REQ-016 rngEn = (state==RUN), combinational; exactly N RNG steps per stream.
REQ-017 Each RUN cycle k: compare (inValReg > rngSeq), unsigned; result registered into bitOut with bitVld=1 at k+1; bitVld high for exactly N consecutive cycles t+2 .. t+N+1.
REQ-018 done = (state==DONE), asserted at cycle t+N+1, coincident with the final bitVld.
REQ-019 start is ignored while busy; inValReg is not disturbed mid-stream.
REQ-020 start asserted in the DONE cycle is ignored; a new start is accepted from cycle t+N+2 (IDLE).
REQ-021 abort in RUN or DONE: next cycle state=IDLE, bitVld=0, done=0, and no done pulse for that stream; abort in IDLE has no effect; abort has priority over start in the same cycle.
REQ-022 Boundaries: inVal=0 gives N zeros; inVal=N-1 gives N-1 ones; any N consecutive RNG steps cover all RNG values, so ones emitted = inVal exactly, regardless of RNG phase.
REQ-023 busy = (state!=IDLE).

Reset
REQ-024 rst_n low at a rising edge sets: state=IDLE, inValReg=0, length counter=0, bitOut=0, bitVld=0, onesCnt=0; rngEn, done and busy are 0 as a consequence.
REQ-025 Reset mid-stream discards the stream with no done pulse; the block does not reset the upstream RNG, whose phase is irrelevant per REQ-022.

Configuration
REQ-026 Macro SOBOL_STREAM_ONES_CNT_EN.
- Defined: onesCnt port and counter exist; onesCnt clears on start acceptance, increments on each bitVld&&bitOut, holds after done until the next start, and equals inVal at done.
- Undefined: the port and counter are absent; all other behaviour is identical.

Verification
REQ-027 RWID=8, inVal=100, start one cycle -> bitVld high 256 cycles, exactly 100 ones, done at cycle t+257 with the last bitVld, onesCnt=100 (macro on).
REQ-028 inVal=0, then inVal=255 -> 0 ones, then 255 ones; rngEn high exactly 256 cycles per stream.
REQ-029 start re-pulsed during RUN with inVal=7 (original 200) -> ignored, 200 ones, single done.
REQ-030 abort at RUN cycle 50 -> IDLE next cycle, bitVld=0, no done; following start with inVal=33 -> 33 ones.
REQ-031 rst_n low at RUN cycle 10 -> all outputs 0 next cycle; start accepted after release; 64 ones for inVal=64.
REQ-032 Back-to-back streams: start held high continuously, inVal=1 -> start ignored in DONE, new stream accepted in IDLE, one done per stream, 1 one per stream.
